// File: rtl/div_unit.sv
// Multi-cycle RV64M divide/remainder unit: radix-2 restoring divider with
// valid/ready handshakes and RISC-V-exact handling of divide-by-zero and overflow.
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  funct3,
  input  logic        is_word,
  input  logic [63:0] op_a,
  input  logic [63:0] op_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] result
);

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

  state_t      state;
  logic [6:0]  cnt;
  logic [63:0] rem_q;
  logic [63:0] quo_q;
  logic [63:0] dvsr_q;
  logic        neg_q;
  logic        neg_r;
  logic        rem_sel;
  logic        word_q;

  // Operand decode for the accept cycle.
  logic        signed_op;
  logic [63:0] a_ext, b_ext, a_mag, b_mag, a_sx32;
  logic        a_neg, b_neg;
  logic        div_zero, ovf, special;
  logic [63:0] special_res;

  always_comb begin
    signed_op   = ~funct3[0];
    a_ext       = is_word ? {{32{signed_op & op_a[31]}}, op_a[31:0]} : op_a;
    b_ext       = is_word ? {{32{signed_op & op_b[31]}}, op_b[31:0]} : op_b;
    a_sx32      = {{32{op_a[31]}}, op_a[31:0]};
    a_neg       = signed_op & a_ext[63];
    b_neg       = signed_op & b_ext[63];
    a_mag       = a_neg ? -a_ext : a_ext;
    b_mag       = b_neg ? -b_ext : b_ext;
    div_zero    = (b_ext == 64'd0);
    ovf         = signed_op && (b_ext == '1) &&
                  (a_ext == (is_word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
    special     = ~funct3[2] | div_zero | ovf;
    special_res = 64'd0;
    if (!funct3[2])
      special_res = 64'd0;
    else if (div_zero)
      special_res = funct3[1] ? (is_word ? a_sx32 : op_a) : '1;
    else if (ovf)
      special_res = funct3[1] ? 64'd0 : a_ext;
  end

  // One restoring step: the 65-bit shifted partial remainder can exceed the
  // divisor by up to 2x, so the trial subtract carries an extra borrow bit.
  logic [64:0] shifted;
  logic [65:0] diff;
  logic        ge;

  always_comb begin
    shifted = {rem_q, quo_q[63]};
    diff    = {1'b0, shifted} - {2'b00, dvsr_q};
    ge      = ~diff[65];
  end

  logic [63:0] q_fix, r_fix, sel, fix_res;

  always_comb begin
    q_fix   = neg_q ? -quo_q : quo_q;
    r_fix   = neg_r ? -rem_q : rem_q;
    sel     = rem_sel ? r_fix : q_fix;
    fix_res = word_q ? {{32{sel[31]}}, sel[31:0]} : sel;
  end

  // Control and visible outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples values from before this edge regardless of order.
    if (rst || flush) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= 64'd0;
      cnt       <= 7'd0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          in_ready <= 1'b0;
          if (special) begin
            result    <= special_res;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt   <= is_word ? 7'd32 : 7'd64;
            state <= ITER;
          end
        end
        ITER: begin
          cnt <= cnt - 7'd1;
          if (cnt == 7'd1) state <= FIX;
        end
        FIX: begin
          result    <= fix_res;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the datapath registers are deliberately not reset; they are always
  // loaded at accept before being read, and only control/outputs need a known value.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: if (in_valid) begin
        rem_sel <= funct3[1];
        word_q  <= is_word;
        neg_q   <= a_neg ^ b_neg;
        neg_r   <= a_neg;
        dvsr_q  <= b_mag;
        rem_q   <= 64'd0;
        // W dividends sit in the top half so 32 shifts consume exactly them.
        quo_q   <= is_word ? {a_mag[31:0], 32'd0} : a_mag;
      end
      ITER: begin
        rem_q <= ge ? diff[63:0] : shifted[63:0];
        quo_q <= {quo_q[62:0], ge};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases, handshake/abort
// scenarios and randomized operations against an arithmetic reference model.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, is_word, out_valid, out_ready;
  logic [2:0]  funct3;
  logic [63:0] op_a, op_b, result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_unit dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .funct3(funct3), .is_word(is_word), .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference result straight from the RISC-V M-extension rules.
  function automatic logic [63:0] ref_result(input logic [2:0] f3, input logic w,
                                             input logic [63:0] a, input logic [63:0] b);
    int               sa32, sb32;
    int unsigned      ua32, ub32;
    longint           sa, sb;
    longint unsigned  ua, ub;
    logic [31:0]      t;
    logic [63:0]      r;
    if (!f3[2]) return 64'd0;
    if (w) begin
      ua32 = a[31:0]; ub32 = b[31:0];
      sa32 = a[31:0]; sb32 = b[31:0];
      if (f3[0]) begin
        if (ub32 == 0) t = f3[1] ? ua32 : 32'hFFFF_FFFF;
        else           t = f3[1] ? (ua32 % ub32) : (ua32 / ub32);
      end else begin
        if (sb32 == 0)                                t = f3[1] ? sa32 : 32'hFFFF_FFFF;
        else if (sa32 == int'(32'h8000_0000) && sb32 == -1) t = f3[1] ? 32'd0 : sa32;
        else                                          t = f3[1] ? (sa32 % sb32) : (sa32 / sb32);
      end
      return {{32{t[31]}}, t};
    end
    ua = a; ub = b; sa = a; sb = b;
    if (f3[0]) begin
      if (ub == 0) r = f3[1] ? ua : 64'hFFFF_FFFF_FFFF_FFFF;
      else         r = f3[1] ? (ua % ub) : (ua / ub);
    end else begin
      if (sb == 0)                                               r = f3[1] ? sa : 64'hFFFF_FFFF_FFFF_FFFF;
      else if (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) r = f3[1] ? 64'd0 : a;
      else                                                       r = f3[1] ? (sa % sb) : (sa / sb);
    end
    return r;
  endfunction

  function automatic int ref_latency(input logic [2:0] f3, input logic w,
                                     input logic [63:0] a, input logic [63:0] b);
    logic zero, ov;
    zero = w ? (b[31:0] == 32'd0) : (b == 64'd0);
    ov   = !f3[0] && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                        : (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF));
    if (!f3[2] || zero || ov) return 1;
    return w ? 34 : 66;
  endfunction

  function automatic logic [63:0] rand_operand();
    logic [63:0] v;
    case ($urandom_range(0, 6))
      0: v = 64'd0;
      1: v = 64'hFFFF_FFFF_FFFF_FFFF;
      2: v = 64'h8000_0000_0000_0000;
      3: v = 64'($urandom_range(0, 20));
      4: v = {$urandom, 32'h8000_0000};
      5: v = {32'd0, $urandom};
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  // Issue one op, measure latency from the accept edge, check the result,
  // optionally stall the consumer, then complete the handshake.
  task automatic do_op(input logic [2:0] f3, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input int hold);
    logic [63:0] exp, held;
    int          lat, cyc;
    exp = ref_result(f3, w, a, b);
    lat = ref_latency(f3, w, a, b);
    @(negedge clk);
    check("idle_ready", {63'd0, in_ready}, 64'd1);
    funct3 = f3; is_word = w; op_a = a; op_b = b; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    op_a = {$urandom, $urandom}; op_b = {$urandom, $urandom};
    funct3 = 3'($urandom); is_word = 1'($urandom);
    cyc = 1;
    check("busy_ready", {63'd0, in_ready}, 64'd0);
    while (!out_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("latency", 64'(cyc), 64'(lat));
    check("result", result, exp);
    held = result;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", {63'd0, out_valid}, 64'd1);
      check("hold_result", result, held);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release_valid", {63'd0, out_valid}, 64'd0);
    check("release_ready", {63'd0, in_ready}, 64'd1);
  endtask

  task automatic start_op(input logic [2:0] f3, input logic w, input logic [63:0] a,
                          input logic [63:0] b);
    @(negedge clk);
    funct3 = f3; is_word = w; op_a = a; op_b = b; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  {63'd0, in_ready},  64'd1);
    check({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
    check({tag, "_result"},    result,             64'd0);
  endtask

  initial begin
    logic seen;
    logic [2:0] f3;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    funct3 = 3'd0; is_word = 1'b0; op_a = 64'd0; op_b = 64'd0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    do_op(3'b101, 1'b0, 64'd100, 64'd7, 0);
    do_op(3'b111, 1'b0, 64'd100, 64'd7, 0);
    do_op(3'b100, 1'b0, -64'sd7, 64'd2, 0);
    do_op(3'b110, 1'b0, -64'sd7, 64'd2, 0);
    do_op(3'b110, 1'b0, 64'd7, -64'sd2, 5);
    do_op(3'b011, 1'b0, 64'd9, 64'd3, 0);
    do_op(3'b101, 1'b0, 64'd5, 64'd0, 0);
    do_op(3'b110, 1'b1, 64'h0000_0000_8000_0003, 64'd0, 2);
    do_op(3'b100, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    do_op(3'b110, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    do_op(3'b100, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 0);
    do_op(3'b101, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 0);
    do_op(3'b100, 1'b1, 64'h1234_5678_FFFF_FFF6, 64'd3, 0);

    // Flush during ITER: the op is dropped and never produces a result.
    start_op(3'b100, 1'b0, 64'd1000, 64'd3);
    repeat (19) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check_reset_outputs("flush");
    seen = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("flush_no_valid", {63'd0, seen}, 64'd0);
    do_op(3'b100, 1'b0, 64'd1000, 64'd3, 0);

    // A request coinciding with flush is not accepted.
    @(negedge clk);
    funct3 = 3'b101; is_word = 1'b0; op_a = 64'd50; op_b = 64'd5;
    in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    seen = 1'b0;
    repeat (70) begin
      @(negedge clk);
      if (out_valid || !in_ready) seen = 1'b1;
    end
    check("flush_accept_blocked", {63'd0, seen}, 64'd0);

    // Reset during ITER.
    start_op(3'b101, 1'b0, 64'd12345, 64'd11);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("rst_mid");
    do_op(3'b111, 1'b1, 64'hDEAD_BEEF_0000_0064, 64'd9, 0);

    for (int n = 0; n < 40; n++) begin
      f3 = {($urandom_range(0, 7) != 0), 2'($urandom)};
      do_op(f3, 1'($urandom), rand_operand(), rand_operand(), $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
